// File: rtl/led_seq_pkg.sv
// led_seq_pkg
//   Shared constants for the LED pattern sequencer: mode encodings, bounce
//   direction encodings, and a helper that turns clock frequency and step
//   period into a tick count.
//   No ports (package).
package led_seq_pkg;

    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Divide before multiplying so large clock frequencies do not overflow int.
    function automatic int calc_ticks(input int clk_freq_hz, input int step_ms);
        return (clk_freq_hz / 1000) * step_ms;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen
//   Step-period prescaler. Counts sys_clk cycles and raises tick on the last
//   cycle of each period. The period is TICKS >> speed cycles.
// Ports
//   sys_clk  in   system clock, rising edge
//   sys_rst  in   asynchronous active-high reset
//   run      in   1: count; 0: hold counter at zero
//   clr      in   synchronous counter clear
//   speed    in   [1:0] period divider exponent
//   tick     out  high on the final cycle of the current period
module led_tick_gen #(
    parameter int TICKS = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       run,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int CNT_W = $clog2(TICKS);
    localparam logic [CNT_W:0] TICKS_V = (CNT_W + 1)'(TICKS);
    localparam logic [CNT_W:0] ONE_V   = (CNT_W + 1)'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   limit_m1;

    assign limit_m1 = (TICKS_V >> speed) - ONE_V;

    // >= rather than == so a speed increase that leaves cnt beyond the new
    // limit fires on the next cycle instead of wrapping the counter.
    assign tick = ({1'b0, cnt} >= limit_m1);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (!run || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// led_pattern_seq
//   LED pattern sequencer. Advances a pattern register once per step period
//   (auto mode) or on a manual step request while paused. Four pattern modes:
//   rotate left, rotate right, bounce, blink.
// Ports
//   sys_clk     in   system clock, rising edge
//   sys_rst     in   asynchronous active-high reset
//   enable      in   1: auto-step on tick; 0: paused
//   mode        in   [1:0] 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK
//   speed       in   [1:0] step period = TICKS >> speed
//   step_now    in   manual step request, honoured only while paused
//   led         out  [NUM_LEDS-1:0] pin drive, inverted when ACTIVE_LOW
//   step_pulse  out  one-cycle strobe on the edge the pattern changes
//
//   dir | meaning
//   ----+-------------------------------------------
//   L   | bounce one-hot moving toward bit NUM_LEDS-1
//   R   | bounce one-hot moving toward bit 0
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS    = 3,
    parameter int CLK_FREQ_HZ = 24_000_000,
    parameter int STEP_MS     = 500,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [1:0]          speed,
    input  logic                step_now,
    output logic [NUM_LEDS-1:0] led,
    output logic                step_pulse
);

    localparam int TICKS = calc_ticks(CLK_FREQ_HZ, STEP_MS);
    localparam logic [NUM_LEDS-1:0] PAT_INIT = NUM_LEDS'(1);

    logic [NUM_LEDS-1:0] pat, pat_step, pat_nxt;
    logic [1:0]          mode_q, mode_nxt;
    logic                dir, dir_step, dir_nxt;
    logic                pulse_nxt;
    logic                mode_chg;
    logic                do_step;
    logic                tick;

    led_tick_gen #(
        .TICKS (TICKS)
    ) u_tick_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .run     (enable),
        .clr     (mode_chg),
        .speed   (speed),
        .tick    (tick)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pat        <= PAT_INIT;
            dir        <= DIR_LEFT;
            mode_q     <= MODE_ROT_L;
            step_pulse <= 1'b0;
        end else begin
            pat        <= pat_nxt;
            dir        <= dir_nxt;
            mode_q     <= mode_nxt;
            step_pulse <= pulse_nxt;
        end
    end

    always_comb begin
        mode_chg = (mode != mode_q);
        do_step  = (enable & tick) | (~enable & step_now);

        pat_step = pat;
        dir_step = dir;
        case (mode_q)
            MODE_ROT_L: pat_step = {pat[NUM_LEDS-2:0], pat[NUM_LEDS-1]};
            MODE_ROT_R: pat_step = {pat[0], pat[NUM_LEDS-1:1]};
            MODE_BOUNCE: begin
                // The end LED turns the walk around in the same step, so
                // each end is lit for exactly one step.
                if (dir == DIR_LEFT) begin
                    if (pat[NUM_LEDS-1]) begin
                        dir_step = DIR_RIGHT;
                        pat_step = pat >> 1;
                    end else begin
                        pat_step = pat << 1;
                    end
                end else begin
                    if (pat[0]) begin
                        dir_step = DIR_LEFT;
                        pat_step = pat << 1;
                    end else begin
                        pat_step = pat >> 1;
                    end
                end
            end
            MODE_BLINK: pat_step = ~pat;
            default:    pat_step = pat;
        endcase

        mode_nxt  = mode_q;
        pat_nxt   = pat;
        dir_nxt   = dir;
        pulse_nxt = 1'b0;
        if (mode_chg) begin
            mode_nxt = mode;
            pat_nxt  = (mode == MODE_BLINK) ? '1 : PAT_INIT;
            dir_nxt  = DIR_LEFT;
        end else if (do_step) begin
            pat_nxt   = pat_step;
            dir_nxt   = dir_step;
            pulse_nxt = 1'b1;
        end
    end

    assign led = (ACTIVE_LOW != 0) ? ~pat : pat;

endmodule

// File: tb/tb_led_pattern_seq.sv
module tb_led_pattern_seq;

    typedef struct packed {
        logic [3:0] pat;
        logic       pulse;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       enable;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       step_now;
    logic [3:0] led;
    logic       step_pulse;

    exp_t       sb[$];
    logic [3:0] cur_pat;
    string      phase;
    int         cyc_n    = 0;
    int         checks   = 0;
    int         failures = 0;

    led_pattern_seq #(
        .NUM_LEDS    (4),
        .CLK_FREQ_HZ (1000),
        .STEP_MS     (8),
        .ACTIVE_LOW  (1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .enable     (enable),
        .mode       (mode),
        .speed      (speed),
        .step_now   (step_now),
        .led        (led),
        .step_pulse (step_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_front();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard_empty cyc=%0d", phase, cyc_n);
        end else begin
            e = sb.pop_front();
            assert (led === ~e.pat) else begin
                failures++;
                $error("FAIL %s led cyc=%0d observed=%b expected=%b", phase, cyc_n, led, ~e.pat);
            end
            checks++;
            assert (step_pulse === e.pulse) else begin
                failures++;
                $error("FAIL %s step_pulse cyc=%0d observed=%b expected=%b", phase, cyc_n, step_pulse, e.pulse);
            end
        end
    endtask

    // Push the expectation for the upcoming edge, clock, then compare.
    task automatic cyc(input logic [3:0] p, input logic pl);
        sb.push_back('{pat: p, pulse: pl});
        @(posedge sys_clk);
        #1;
        cyc_n++;
        check_front();
    endtask

    // n-1 quiet cycles holding the current pattern, then one step to np.
    task automatic wait_steps(input int n, input logic [3:0] np);
        repeat (n - 1) cyc(cur_pat, 1'b0);
        cyc(np, 1'b1);
        cur_pat = np;
    endtask

    task automatic check_async_reset(input string tag);
        checks++;
        assert (led === 4'b1110) else begin
            failures++;
            $error("FAIL %s led observed=%b expected=%b", tag, led, 4'b1110);
        end
        checks++;
        assert (step_pulse === 1'b0) else begin
            failures++;
            $error("FAIL %s step_pulse observed=%b expected=%b", tag, step_pulse, 1'b0);
        end
    endtask

    task automatic check_dir(input string tag, input logic exp_dir);
        checks++;
        assert (dut.dir === exp_dir) else begin
            failures++;
            $error("FAIL %s dir observed=%b expected=%b", tag, dut.dir, exp_dir);
        end
    endtask

    initial begin
        sys_rst  = 1'b1;
        enable   = 1'b1;
        mode     = 2'd0;
        speed    = 2'd0;
        step_now = 1'b0;
        #3;
        check_async_reset("reset_state");

        // Rotate left, 8-cycle period
        phase = "rot_l";
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        cur_pat = 4'b0001;
        wait_steps(8, 4'b0010);
        wait_steps(8, 4'b0100);
        wait_steps(8, 4'b1000);
        wait_steps(8, 4'b0001);

        // Bounce from reset; first edge is the mode change
        phase = "bounce";
        sys_rst = 1'b1;
        mode    = 2'd2;
        #1;
        check_async_reset("reset_again");
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        cur_pat = 4'b0001;
        cyc(4'b0001, 1'b0);
        wait_steps(8, 4'b0010);
        wait_steps(8, 4'b0100);
        wait_steps(8, 4'b1000);
        check_dir("bounce_at_top", 1'b0);
        wait_steps(8, 4'b0100);
        check_dir("bounce_turned_right", 1'b1);
        wait_steps(8, 4'b0010);
        wait_steps(8, 4'b0001);
        check_dir("bounce_at_bottom", 1'b1);
        wait_steps(8, 4'b0010);
        check_dir("bounce_turned_left", 1'b0);
        wait_steps(8, 4'b0100);
        wait_steps(8, 4'b1000);
        wait_steps(8, 4'b0100);

        // Async reset mid-bounce with dir=RIGHT
        phase = "async_reset";
        repeat (3) cyc(cur_pat, 1'b0);
        #2;
        sys_rst = 1'b1;
        mode    = 2'd0;
        #1;
        check_async_reset("async_reset_mid_bounce");
        check_dir("async_reset_dir", 1'b0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        cur_pat = 4'b0001;
        wait_steps(8, 4'b0010);

        // Switch to blink at cnt=5
        phase = "blink";
        repeat (5) cyc(cur_pat, 1'b0);
        mode = 2'd3;
        cyc(4'b1111, 1'b0);
        cur_pat = 4'b1111;
        wait_steps(8, 4'b0000);
        wait_steps(8, 4'b1111);

        // Paused manual stepping in rotate right
        phase = "manual";
        enable = 1'b0;
        mode   = 2'd1;
        cyc(4'b0001, 1'b0);
        cur_pat = 4'b0001;
        step_now = 1'b1;
        wait_steps(1, 4'b1000);
        step_now = 1'b0;
        repeat (2) cyc(cur_pat, 1'b0);
        step_now = 1'b1;
        wait_steps(1, 4'b0100);
        step_now = 1'b0;
        cyc(cur_pat, 1'b0);
        step_now = 1'b1;
        wait_steps(1, 4'b0010);
        step_now = 1'b0;
        repeat (3) cyc(cur_pat, 1'b0);

        // step_now ignored while enabled; full period after re-enable
        phase = "enabled_step_now";
        enable   = 1'b1;
        step_now = 1'b1;
        cyc(cur_pat, 1'b0);
        step_now = 1'b0;
        wait_steps(7, 4'b0001);

        // Speed raise mid-count, then x4
        phase = "speed";
        repeat (4) cyc(cur_pat, 1'b0);
        speed = 2'd3;
        wait_steps(1, 4'b1000);
        wait_steps(1, 4'b0100);
        wait_steps(1, 4'b0010);
        wait_steps(1, 4'b0001);
        speed = 2'd2;
        wait_steps(2, 4'b1000);
        wait_steps(2, 4'b0100);
        wait_steps(2, 4'b0010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
